exec_stage: RTL and testbench
=============================

// Module: exec_stage
// PURPOSE
//  Execute stage of the multi-cycle core. Active while state==2; feeds the memory stage (state==3).
//  Computes ALU result, load/store address, store data, branch decision and target.
//  Holds all results in registers through state 3. Multi-cycle divide holds the core via exec_done.
// PARAMETERS
//  XLEN      32  datapath width; only 32 is supported
//  DIV_STEPS 32  restoring-divide iterations; must equal XLEN
// PORTS
//  clk             in   1   core clock
//  rst             in   1   synchronous active-high reset
//  state           in   3   core phase; 2 = execute
//  alu_op          in   4   0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 DIV,11 DIVU,12 REM,13 REMU
//  alu_src         in   1   1: operand B = imm, 0: rs2_val
//  branch_op       in   3   0 none,1 BEQ,2 BNE,3 BLT,4 BGE,5 BLTU,6 BGEU,7 jump
//  jump_reg        in   1   target base is rs1_val (JALR) instead of pc
//  rs1_val,rs2_val in   32  register operands
//  imm,pc          in   32  sign-extended immediate; address of this instruction
//  mem_read_in,mem_write_in,reg_write_in in 1 decode controls
//  write_reg_in    in   5   destination register
//  mem_read,mem_write out 1 registered copies for memory stage
//  mem_addr        out  32  rs1_val+imm
//  mem_write_data  out  32  rs2_val
//  branch          out  1   branch/jump taken
//  branch_addr     out  32  target; JALR clears bit 0
//  reg_write       out  1   registered reg_write_in
//  write_reg       out  5   registered write_reg_in
//  reg_write_data  out  32  ALU/divide result; pc+4 when branch_op==7
//  exec_done       out  1   results valid; controller leaves state 2 only when high
// BEHAVIOUR
//  - Reset: every output 0, FSM IDLE, iteration counter 0. Reset mid-divide aborts it, no result written.
//  - FSM IDLE/BUSY/DONE. IDLE & state==2:
//    - non-divide op: all outputs registered at that edge, -> DONE; exec_done high next cycle (latency 1).
//    - divide op: operands latched, -> BUSY.
//  - BUSY: one quotient bit per cycle for DIV_STEPS cycles, then outputs registered, -> DONE.
//    exec_done rises 34 cycles after state becomes 2.
//  - DONE: exec_done=1, all outputs frozen. When state!=2: -> IDLE, exec_done=0.
//    Outputs stay frozen through state 3 and change only at the next execute.
//  - state leaves 2 while BUSY: abort -> IDLE, outputs unchanged, exec_done stays 0.
//  - Shifts use B[4:0]. SLT/BLT/BGE compare signed; SLTU/BLTU/BGEU unsigned. Adds wrap modulo 2^32.
//  - Signed divide runs on magnitudes; quotient sign = sign(a)^sign(b), remainder takes sign of dividend.
//  - Div by 0: single-cycle path, quotient 0xFFFFFFFF, remainder = dividend.
//  - 0x80000000 / -1 (signed): single-cycle path, quotient 0x80000000, remainder 0.
//  - branch_addr = (jump_reg ? rs1_val : pc) + imm.
//  - branch = condition(rs1_val, rs2_val) or (branch_op==7); branch_op==0 -> 0.
// CONFIGURATION
//  EXEC_DIV_EN defined: iterative divider above is present.
//  EXEC_DIV_EN undefined: no divider logic; alu_op 10-13 complete in 1 cycle with reg_write_data=0.
//  Ops 14-15 always give 0 in 1 cycle.
// TESTING
//  ADD rs1=5 rs2=7, state 2 -> exec_done next cycle, reg_write_data=12, branch=0.
//  SW rs1=0x100 imm=-4 rs2=0xAB -> mem_addr=0xFC, mem_write_data=0xAB, mem_write=1.
//  BLT rs1=-1 rs2=1 pc=0x40 imm=8 -> branch=1, branch_addr=0x48; BLTU same -> branch=0.
//  JALR rs1=0x201 imm=2 pc=0x10 -> branch_addr=0x202, reg_write_data=0x14.
//  EXEC_DIV_EN: DIV -7/2 -> done after 34 cycles, q=-3; REM -> -1; DIVU x/0 -> 0xFFFFFFFF in 1 cycle.
//  rst pulsed 10 cycles into a DIV -> all outputs 0, exec_done 0; next ADD completes normally.

Source files
------------

// File: rtl/exec_stage_if.sv
// exec_stage_if: decode-side controls/operands in, registered memory/writeback results out
interface exec_stage_if;
    logic [2:0]  state;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic [2:0]  branch_op;
    logic        jump_reg;
    logic [31:0] rs1_val, rs2_val, imm, pc;
    logic        mem_read_in, mem_write_in, reg_write_in;
    logic [4:0]  write_reg_in;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_write_data;
    logic        branch;
    logic [31:0] branch_addr;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] reg_write_data;
    logic        exec_done;
    modport master (
        output state, alu_op, alu_src, branch_op, jump_reg, rs1_val, rs2_val, imm, pc,
               mem_read_in, mem_write_in, reg_write_in, write_reg_in,
        input  mem_read, mem_write, mem_addr, mem_write_data, branch, branch_addr,
               reg_write, write_reg, reg_write_data, exec_done
    );
    modport slave (
        input  state, alu_op, alu_src, branch_op, jump_reg, rs1_val, rs2_val, imm, pc,
               mem_read_in, mem_write_in, reg_write_in, write_reg_in,
        output mem_read, mem_write, mem_addr, mem_write_data, branch, branch_addr,
               reg_write, write_reg, reg_write_data, exec_done
    );
endinterface

// File: rtl/exec_stage.sv
// exec_stage: execute stage ALU/branch/result registers; EXEC_DIV_EN adds a 32-step restoring divider
module exec_stage #(
    parameter int XLEN      = 32,
    parameter int DIV_STEPS = 32
) (
    input logic         clk,
    input logic         rst,
    exec_stage_if.slave e
);
    if (XLEN != 32 || DIV_STEPS != XLEN) begin : g_cfg_check
        $error("exec_stage supports only XLEN = DIV_STEPS = 32");
    end
    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;
    fsm_t st, st_nx;
    logic [XLEN-1:0] a, b, alu_res, fast_res, div_res, tgt;
    logic [4:0] sh;
    logic slow, div_last, start, cap, take, eq, lt, ltu;
    assign a  = e.rs1_val;
    assign b  = e.alu_src ? e.imm : e.rs2_val;
    assign sh = b[4:0];
    always_comb begin
        alu_res = '0;
        case (e.alu_op)
            4'd0: alu_res = a + b;
            4'd1: alu_res = a - b;
            4'd2: alu_res = a << sh;
            4'd3: alu_res = XLEN'($signed(a) < $signed(b));
            4'd4: alu_res = XLEN'(a < b);
            4'd5: alu_res = a ^ b;
            4'd6: alu_res = a >> sh;
            4'd7: alu_res = $unsigned($signed(a) >>> sh);
            4'd8: alu_res = a | b;
            4'd9: alu_res = a & b;
            default: alu_res = '0;
        endcase
    end
    assign eq   = e.rs1_val == e.rs2_val;
    assign lt   = $signed(e.rs1_val) < $signed(e.rs2_val);
    assign ltu  = e.rs1_val < e.rs2_val;
    assign take = e.branch_op == 3'd1 ? eq :
                  e.branch_op == 3'd2 ? !eq :
                  e.branch_op == 3'd3 ? lt :
                  e.branch_op == 3'd4 ? !lt :
                  e.branch_op == 3'd5 ? ltu :
                  e.branch_op == 3'd6 ? !ltu :
                  e.branch_op == 3'd7;
    assign tgt  = (e.jump_reg ? a : e.pc) + e.imm;
`ifdef EXEC_DIV_EN
    logic is_div, sgn, want_rem, a_neg, b_neg, div0, ovf, q_neg_r, r_neg_r, want_rem_r;
    logic [XLEN-1:0] a_mag, b_mag, rem_r, quo_r, dvs_r;
    logic [XLEN:0] trial;
    logic [5:0] cnt;
    assign is_div   = e.alu_op inside {4'd10, 4'd11, 4'd12, 4'd13};
    assign sgn      = e.alu_op == 4'd10 || e.alu_op == 4'd12;
    assign want_rem = e.alu_op[3:2] == 2'b11;
    assign a_neg    = sgn & a[XLEN-1];
    assign b_neg    = sgn & b[XLEN-1];
    assign a_mag    = a_neg ? -a : a;
    assign b_mag    = b_neg ? -b : b;
    assign div0     = b == '0;
    assign ovf      = sgn && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1;
    assign slow     = is_div && !div0 && !ovf;
    // overflow case: quotient equals the dividend (0x80000000), remainder 0
    assign fast_res = !is_div ? alu_res : div0 ? (want_rem ? a : '1) : (want_rem ? '0 : a);
    assign trial    = {rem_r, quo_r[XLEN-1]} - {1'b0, dvs_r};
    assign div_last = cnt == 6'(DIV_STEPS);
    assign div_res  = want_rem_r ? (r_neg_r ? -rem_r : rem_r) : (q_neg_r ? -quo_r : quo_r);
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            rem_r      <= '0;
            quo_r      <= '0;
            dvs_r      <= '0;
            q_neg_r    <= 1'b0;
            r_neg_r    <= 1'b0;
            want_rem_r <= 1'b0;
        end else if (start) begin
            cnt        <= '0;
            rem_r      <= '0;
            quo_r      <= a_mag;
            dvs_r      <= b_mag;
            q_neg_r    <= a_neg ^ b_neg;
            r_neg_r    <= a_neg;
            want_rem_r <= want_rem;
        end else if (st == BUSY && !div_last) begin
            rem_r <= trial[XLEN] ? {rem_r[XLEN-2:0], quo_r[XLEN-1]} : trial[XLEN-1:0];
            quo_r <= {quo_r[XLEN-2:0], !trial[XLEN]};
            cnt   <= cnt + 6'd1;
        end
    end
`else
    assign slow     = 1'b0;
    assign div_last = 1'b1;
    assign div_res  = '0;
    assign fast_res = alu_res;
`endif
    assign start = st == IDLE && e.state == 3'd2 && slow;
    always_comb begin
        st_nx = st;
        cap   = 1'b0;
        case (st)
            IDLE: if (e.state == 3'd2) begin
                st_nx = slow ? BUSY : DONE;
                cap   = !slow;
            end
            BUSY: if (e.state != 3'd2) st_nx = IDLE;
                  else if (div_last) begin
                      st_nx = DONE;
                      cap   = 1'b1;
                  end
            DONE: if (e.state != 3'd2) st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) st <= rst ? IDLE : st_nx;
    always_ff @(posedge clk) begin
        if (rst) begin
            e.mem_read       <= 1'b0;
            e.mem_write      <= 1'b0;
            e.mem_addr       <= '0;
            e.mem_write_data <= '0;
            e.branch         <= 1'b0;
            e.branch_addr    <= '0;
            e.reg_write      <= 1'b0;
            e.write_reg      <= '0;
            e.reg_write_data <= '0;
        end else if (cap) begin
            e.mem_read       <= e.mem_read_in;
            e.mem_write      <= e.mem_write_in;
            e.mem_addr       <= e.rs1_val + e.imm;
            e.mem_write_data <= e.rs2_val;
            e.branch         <= take;
            e.branch_addr    <= e.jump_reg ? {tgt[XLEN-1:1], 1'b0} : tgt;
            e.reg_write      <= e.reg_write_in;
            e.write_reg      <= e.write_reg_in;
            e.reg_write_data <= e.branch_op == 3'd7 ? e.pc + XLEN'(4) : (st == BUSY ? div_res : fast_res);
        end
    end
    assign e.exec_done = st == DONE;
endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: random and directed stimulus against an arithmetic reference model of the execute stage
module tb_exec_stage;
    typedef struct {
        logic [3:0]  op;
        logic        src;
        logic [2:0]  bop;
        logic        jr;
        logic [31:0] r1, r2, im, pc;
        logic        mr, mw, rw;
        logic [4:0]  wr;
    } op_t;
    typedef struct {
        logic        mr, mw, br, rw;
        logic [31:0] ma, mwd, ba, rwd;
        logic [4:0]  wr;
        int          lat;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    exec_stage_if bus();
    exec_stage dut (.clk(clk), .rst(rst), .e(bus));
    always #5 clk = ~clk;
    initial begin
        #10000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic exp_t model(input op_t o);
        exp_t x;
        logic [31:0] b, q, rr, base, alu;
        b     = o.src ? o.im : o.r2;
        x.lat = 1;
        case (o.op)
            4'd0: alu = o.r1 + b;
            4'd1: alu = o.r1 - b;
            4'd2: alu = o.r1 << (b % 32);
            4'd3: alu = ($signed(o.r1) < $signed(b)) ? 1 : 0;
            4'd4: alu = (o.r1 < b) ? 1 : 0;
            4'd5: alu = o.r1 ^ b;
            4'd6: alu = o.r1 >> (b % 32);
            4'd7: alu = $unsigned($signed(o.r1) >>> (b % 32));
            4'd8: alu = o.r1 | b;
            4'd9: alu = o.r1 & b;
            default: alu = 0;
        endcase
`ifdef EXEC_DIV_EN
        if (o.op >= 10 && o.op <= 13) begin
            if (b == 0) begin
                q  = 32'hFFFF_FFFF;
                rr = o.r1;
            end else if ((o.op == 10 || o.op == 12) && o.r1 == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q  = 32'h8000_0000;
                rr = 0;
            end else begin
                x.lat = 34;
                if (o.op == 10 || o.op == 12) begin
                    q  = $signed(o.r1) / $signed(b);
                    rr = $signed(o.r1) % $signed(b);
                end else begin
                    q  = o.r1 / b;
                    rr = o.r1 % b;
                end
            end
            alu = (o.op >= 12) ? rr : q;
        end
`endif
        case (o.bop)
            3'd1: x.br = o.r1 == o.r2;
            3'd2: x.br = o.r1 != o.r2;
            3'd3: x.br = $signed(o.r1) < $signed(o.r2);
            3'd4: x.br = $signed(o.r1) >= $signed(o.r2);
            3'd5: x.br = o.r1 < o.r2;
            3'd6: x.br = o.r1 >= o.r2;
            3'd7: x.br = 1'b1;
            default: x.br = 1'b0;
        endcase
        base = o.jr ? o.r1 : o.pc;
        x.ba = base + o.im;
        if (o.jr) x.ba[0] = 1'b0;
        x.rwd = (o.bop == 7) ? o.pc + 4 : alu;
        x.ma  = o.r1 + o.im;
        x.mwd = o.r2;
        x.mr  = o.mr;
        x.mw  = o.mw;
        x.rw  = o.rw;
        x.wr  = o.wr;
        return x;
    endfunction
    task automatic drive(input op_t o);
        bus.alu_op       = o.op;
        bus.alu_src      = o.src;
        bus.branch_op    = o.bop;
        bus.jump_reg     = o.jr;
        bus.rs1_val      = o.r1;
        bus.rs2_val      = o.r2;
        bus.imm          = o.im;
        bus.pc           = o.pc;
        bus.mem_read_in  = o.mr;
        bus.mem_write_in = o.mw;
        bus.reg_write_in = o.rw;
        bus.write_reg_in = o.wr;
    endtask
    function automatic op_t rnd();
        op_t o;
        logic [31:0] v;
        o.op  = 4'($urandom_range(0, 15));
        o.src = 1'($urandom_range(0, 1));
        o.bop = 3'($urandom_range(0, 7));
        o.jr  = 1'($urandom_range(0, 1));
        o.r1  = $urandom;
        case ($urandom_range(0, 7))
            0: v = 0;
            1: begin v = 32'hFFFF_FFFF; o.r1 = 32'h8000_0000; end
            2: v = $urandom_range(1, 9);
            3: v = -$urandom_range(1, 9);
            4: begin v = $urandom; o.r1 = v; end
            default: v = $urandom;
        endcase
        o.r2 = v;
        o.im = o.src ? v : $urandom;
        o.pc = $urandom & 32'hFFFF_FFFC;
        o.mr = 1'($urandom_range(0, 1));
        o.mw = 1'($urandom_range(0, 1));
        o.rw = 1'($urandom_range(0, 1));
        o.wr = 5'($urandom_range(0, 31));
        return o;
    endfunction
    task automatic cmp_outs(input exp_t x);
        check("mem_read", bus.mem_read, x.mr);
        check("mem_write", bus.mem_write, x.mw);
        check("mem_addr", bus.mem_addr, x.ma);
        check("mem_write_data", bus.mem_write_data, x.mwd);
        check("branch", bus.branch, x.br);
        check("branch_addr", bus.branch_addr, x.ba);
        check("reg_write", bus.reg_write, x.rw);
        check("write_reg", bus.write_reg, x.wr);
        check("reg_write_data", bus.reg_write_data, x.rwd);
    endtask
    task automatic run(input op_t o);
        exp_t x;
        int cyc;
        x = model(o);
        drive(o);
        bus.state = 3'd2;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!bus.exec_done && cyc < 100);
        check("latency", cyc, x.lat);
        cmp_outs(x);
        bus.state = 3'd3;
        drive(rnd());
        tick();
        check("done_drop", bus.exec_done, 0);
        tick();
        cmp_outs(x);
        bus.state = 3'd0;
        tick();
    endtask
    initial begin
        op_t o;
        exp_t z;
        z = '{default: 0};
        bus.state = 3'd0;
        drive('{default: 0});
        repeat (3) tick();
        rst = 1'b0;
        cmp_outs(z);
        check("rst_done", bus.exec_done, 0);
        run('{4'd0, 1'b0, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd3});
        check("add_lit", bus.reg_write_data, 32'd12);
        check("add_br_lit", bus.branch, 0);
        run('{4'd0, 1'b1, 3'd0, 1'b0, 32'h100, 32'hAB, 32'hFFFF_FFFC, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0});
        check("sw_addr_lit", bus.mem_addr, 32'hFC);
        check("sw_data_lit", bus.mem_write_data, 32'hAB);
        check("sw_we_lit", bus.mem_write, 1);
        run('{4'd1, 1'b0, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd8, 32'h40, 1'b0, 1'b0, 1'b0, 5'd0});
        check("blt_lit", bus.branch, 1);
        check("blt_tgt_lit", bus.branch_addr, 32'h48);
        run('{4'd1, 1'b0, 3'd5, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd8, 32'h40, 1'b0, 1'b0, 1'b0, 5'd0});
        check("bltu_lit", bus.branch, 0);
        run('{4'd0, 1'b1, 3'd7, 1'b1, 32'h201, 32'd0, 32'd2, 32'h10, 1'b0, 1'b0, 1'b1, 5'd1});
        check("jalr_tgt_lit", bus.branch_addr, 32'h202);
        check("jalr_link_lit", bus.reg_write_data, 32'h14);
        run('{4'd10, 1'b0, 3'd0, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd4});
`ifdef EXEC_DIV_EN
        check("div_lit", bus.reg_write_data, 32'hFFFF_FFFD);
        run('{4'd12, 1'b0, 3'd0, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd4});
        check("rem_lit", bus.reg_write_data, 32'hFFFF_FFFF);
        run('{4'd11, 1'b0, 3'd0, 1'b0, 32'd1234, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd4});
        check("divu0_lit", bus.reg_write_data, 32'hFFFF_FFFF);
        // leaving execute mid-divide must keep the previous ADD result
        run('{4'd0, 1'b0, 3'd0, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd2});
        drive('{4'd11, 1'b0, 3'd0, 1'b0, 32'd100, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd9});
        bus.state = 3'd2;
        repeat (5) tick();
        bus.state = 3'd3;
        repeat (3) tick();
        check("abort_done", bus.exec_done, 0);
        check("abort_hold", bus.reg_write_data, 32'd3);
        check("abort_wr_hold", bus.write_reg, 32'd2);
        bus.state = 3'd0;
        tick();
`endif
        drive('{4'd10, 1'b0, 3'd0, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd4, 32'd8, 1'b1, 1'b1, 1'b1, 5'd7});
        bus.state = 3'd2;
        repeat (10) tick();
        rst = 1'b1;
        bus.state = 3'd0;
        tick();
        rst = 1'b0;
        cmp_outs(z);
        check("rst_mid_done", bus.exec_done, 0);
        tick();
        check("rst_mid_idle", bus.exec_done, 0);
        run('{4'd0, 1'b0, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd3});
        check("add_after_rst", bus.reg_write_data, 32'd12);
        for (int i = 0; i < 60; i++) begin
            o = rnd();
            run(o);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
